// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: writeback request FIFO that drains one entry per cycle
// into the regfile write port.
// Pending writes are forwarded to the two snooped read addresses.
// The forwarding network is built only when REGFILE_WB_FWD_EN is defined.
// Otherwise the fwd* outputs are tied to zero.
module regfile_wb_queue #(
    parameter int RWIDTH = 6,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RWIDTH-1:0]          in_addr,
    input  logic [DWIDTH-1:0]          in_data,
    input  logic                       flush,
    input  logic                       rf_stall,
    output logic                       rf_we,
    output logic [RWIDTH-1:0]          rf_wa,
    output logic [DWIDTH-1:0]          rf_wd,
    input  logic [RWIDTH-1:0]          ra1,
    input  logic [RWIDTH-1:0]          ra2,
    output logic                       fwd1_hit,
    output logic [DWIDTH-1:0]          fwd1_data,
    output logic                       fwd2_hit,
    output logic [DWIDTH-1:0]          fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [RWIDTH-1:0] r_mem_addr [DEPTH];
    logic [DWIDTH-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    // Fullness comes from the registered count, so a pop in the same cycle
    // cannot reopen the input.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && !flush;
    assign w_pop    = rf_we;
    assign count    = r_count;

    // Drain the head into the regfile unless stalled or flushing.
    always_comb begin
        rf_we = !w_empty && !rf_stall && !flush;
        rf_wa = '0;
        rf_wd = '0;
        if (!w_empty) begin
            rf_wa = r_mem_addr[r_rd_ptr];
            rf_wd = r_mem_data[r_rd_ptr];
        end
    end

    // Entry storage: write the accepted request at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_addr[r_wr_ptr] <= in_addr;
            r_mem_data[r_wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy update; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Scan occupied entries oldest to youngest; a later match overwrites
    // an earlier one, so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PW'(i);
            if (i < 32'(r_count)) begin
                if (r_mem_addr[idx] == ra1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = r_mem_data[idx];
                end
                if (r_mem_addr[idx] == ra2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = r_mem_data[idx];
                end
            end
        end
    end
`else
    logic w_unused_ra;
    assign w_unused_ra = ^{ra1, ra2};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule
